// File: rtl/netlist_record_decoder.sv
// netlist_record_decoder
// Byte-stream decoder for framed component instance records. Parses
// SYNC, TYPE, NPAR, NPAR x (LO,HI), NNOD, NNOD x NODE, CSUM frames into
// type, indexed parameter and indexed node outputs. It also checks the
// count fields and the XOR checksum.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_data/in_valid     input byte stream
//   in_ready             byte accepted when in_valid && in_ready
//   type_out/type_valid  component type, pulse on update
//   param_idx/param_val  parameter index and little-endian 16-bit value
//   param_valid          pulse on a new parameter
//   node_idx/node_val    node index and node number
//   node_valid           pulse on a new node
//   rec_done/rec_ok      end-of-record pulse, checksum result (held)
//   err_len              pulse when a count field is out of range
//   drop_cnt             saturating count of bytes discarded while hunting
//   busy                 high whenever not hunting for SYNC
module netlist_record_decoder #(
    parameter int unsigned MAX_PARAMS = 8,
    parameter int unsigned MAX_NODES  = 16,
    parameter logic [7:0]  SYNC_BYTE  = 8'hA5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [7:0]  type_out,
    output logic        type_valid,
    output logic [3:0]  param_idx,
    output logic [15:0] param_val,
    output logic        param_valid,
    output logic [3:0]  node_idx,
    output logic [7:0]  node_val,
    output logic        node_valid,
    output logic        rec_done,
    output logic        rec_ok,
    output logic        err_len,
    output logic [15:0] drop_cnt,
    output logic        busy
);

    localparam int unsigned CNT_W    = 5;
    localparam logic [7:0]  MAX_PAR_B = 8'(MAX_PARAMS);
    localparam logic [7:0]  MAX_NOD_B = 8'(MAX_NODES);

    typedef enum logic [3:0] {
        S_HUNT, S_TYPE, S_NPAR, S_PLO, S_PHI, S_NNOD, S_NODE, S_CSUM, S_DONE
    } state_t;

    state_t state, state_next;

    // Internal datapath state
    logic [7:0]       lo_q, lo_d;
    logic [7:0]       xor_q, xor_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] total_q, total_d;

    // Next values of registered outputs
    logic        in_ready_d, busy_d;
    logic [7:0]  type_d;
    logic        type_valid_d;
    logic [3:0]  param_idx_d;
    logic [15:0] param_val_d;
    logic        param_valid_d;
    logic [3:0]  node_idx_d;
    logic [7:0]  node_val_d;
    logic        node_valid_d;
    logic        rec_done_d, rec_ok_d, err_len_d;
    logic [15:0] drop_d;

    logic fire;
    logic last;

    assign fire = in_valid && in_ready;
    // Current param/node is the final one of its group
    assign last = (cnt_q + CNT_W'(1)) == total_q;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_HUNT;
        else        state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            S_HUNT: if (fire && in_data == SYNC_BYTE) state_next = S_TYPE;
            S_TYPE: if (fire) state_next = S_NPAR;
            S_NPAR: if (fire) begin
                if (in_data == 8'd0)           state_next = S_NNOD;
                else if (in_data > MAX_PAR_B)  state_next = S_HUNT;
                else                           state_next = S_PLO;
            end
            S_PLO:  if (fire) state_next = S_PHI;
            S_PHI:  if (fire) state_next = last ? S_NNOD : S_PLO;
            S_NNOD: if (fire) begin
                if (in_data == 8'd0)           state_next = S_CSUM;
                else if (in_data > MAX_NOD_B)  state_next = S_HUNT;
                else                           state_next = S_NODE;
            end
            S_NODE: if (fire && last) state_next = S_CSUM;
            S_CSUM: if (fire) state_next = S_DONE;
            S_DONE: state_next = S_HUNT;
            default: state_next = S_HUNT;
        endcase
    end

    // Output and datapath next values
    always_comb begin
        lo_d          = lo_q;
        xor_d         = xor_q;
        cnt_d         = cnt_q;
        total_d       = total_q;
        type_d        = type_out;
        type_valid_d  = 1'b0;
        param_idx_d   = param_idx;
        param_val_d   = param_val;
        param_valid_d = 1'b0;
        node_idx_d    = node_idx;
        node_val_d    = node_val;
        node_valid_d  = 1'b0;
        rec_done_d    = 1'b0;
        rec_ok_d      = rec_ok;
        err_len_d     = 1'b0;
        drop_d        = drop_cnt;
        // DONE deasserts in_ready for its single cycle
        in_ready_d    = (state_next != S_DONE);
        busy_d        = (state_next != S_HUNT);

        if (fire) begin
            case (state)
                S_HUNT: begin
                    if (in_data == SYNC_BYTE) begin
                        xor_d       = 8'd0;
                        cnt_d       = '0;
                        param_idx_d = 4'd0;
                        node_idx_d  = 4'd0;
                    end else if (drop_cnt != 16'hFFFF) begin
                        drop_d = drop_cnt + 16'd1;
                    end
                end
                S_TYPE: begin
                    type_d       = in_data;
                    type_valid_d = 1'b1;
                    xor_d        = xor_q ^ in_data;
                end
                S_NPAR: begin
                    xor_d = xor_q ^ in_data;
                    cnt_d = '0;
                    if (in_data > MAX_PAR_B) err_len_d = 1'b1;
                    else                     total_d   = CNT_W'(in_data);
                end
                S_PLO: begin
                    lo_d  = in_data;
                    xor_d = xor_q ^ in_data;
                end
                S_PHI: begin
                    param_val_d   = {in_data, lo_q};
                    param_idx_d   = cnt_q[3:0];
                    param_valid_d = 1'b1;
                    cnt_d         = cnt_q + CNT_W'(1);
                    xor_d         = xor_q ^ in_data;
                end
                S_NNOD: begin
                    xor_d = xor_q ^ in_data;
                    cnt_d = '0;
                    if (in_data > MAX_NOD_B) err_len_d = 1'b1;
                    else                     total_d   = CNT_W'(in_data);
                end
                S_NODE: begin
                    node_val_d   = in_data;
                    node_idx_d   = cnt_q[3:0];
                    node_valid_d = 1'b1;
                    cnt_d        = cnt_q + CNT_W'(1);
                    xor_d        = xor_q ^ in_data;
                end
                S_CSUM: begin
                    rec_ok_d   = (in_data == xor_q);
                    rec_done_d = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Output and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lo_q        <= 8'd0;
            xor_q       <= 8'd0;
            cnt_q       <= '0;
            total_q     <= '0;
            in_ready    <= 1'b0;
            busy        <= 1'b0;
            type_out    <= 8'd0;
            type_valid  <= 1'b0;
            param_idx   <= 4'd0;
            param_val   <= 16'd0;
            param_valid <= 1'b0;
            node_idx    <= 4'd0;
            node_val    <= 8'd0;
            node_valid  <= 1'b0;
            rec_done    <= 1'b0;
            rec_ok      <= 1'b0;
            err_len     <= 1'b0;
            drop_cnt    <= 16'd0;
        end else begin
            lo_q        <= lo_d;
            xor_q       <= xor_d;
            cnt_q       <= cnt_d;
            total_q     <= total_d;
            in_ready    <= in_ready_d;
            busy        <= busy_d;
            type_out    <= type_d;
            type_valid  <= type_valid_d;
            param_idx   <= param_idx_d;
            param_val   <= param_val_d;
            param_valid <= param_valid_d;
            node_idx    <= node_idx_d;
            node_val    <= node_val_d;
            node_valid  <= node_valid_d;
            rec_done    <= rec_done_d;
            rec_ok      <= rec_ok_d;
            err_len     <= err_len_d;
            drop_cnt    <= drop_d;
        end
    end

endmodule
